// File: rtl/hazard_sequencer_if.sv
// Signal bundle between the pipeline and the hazard sequencer: decode/execute fields and
// mdu_done in, stall/flush strobes and the multi-cycle unit handshake out.
interface hazard_sequencer_if;
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic [4:0] rd_E;
    logic [1:0] ResultSrc_E;
    logic [1:0] PCSrc_E;
    logic       MulDiv_E;
    logic       mdu_done;
    logic       Stall_F;
    logic       Stall_D;
    logic       Stall_E;
    logic       Flush_D;
    logic       Flush_E;
    logic       Flush_M;
    logic       mdu_start;
    logic       mdu_timeout;
    logic       mdu_busy;

    // The hazard sequencer itself.
    modport master (
        input  rs1_D, rs2_D, rd_E, ResultSrc_E, PCSrc_E, MulDiv_E, mdu_done,
        output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
        output mdu_start, mdu_timeout, mdu_busy
    );

    // The pipeline and multi-cycle unit side.
    modport slave (
        output rs1_D, rs2_D, rd_E, ResultSrc_E, PCSrc_E, MulDiv_E, mdu_done,
        input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
        input  mdu_start, mdu_timeout, mdu_busy
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and multi-cycle EX sequencing.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_events performance counters.
module hazard_sequencer #(
    parameter int unsigned MDU_MAX_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic               clk,
    input  logic               rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_events,
`endif
    hazard_sequencer_if.master hz
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MDU_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntSat  = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             lw_hazard;
    logic             redirect;
    logic             cnt_expired;

    assign lw_hazard = (hz.ResultSrc_E == 2'b01) && (hz.rd_E != 5'd0) &&
                       ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    assign redirect    = |hz.PCSrc_E;
    assign cnt_expired = (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (hz.MulDiv_E && !redirect) begin
                    state_d = StBusy;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                if (cnt_q != CntSat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A done on the expiry cycle wins: no timeout pulse.
                if (hz.mdu_done || cnt_expired) begin
                    state_d   = StDone;
                    timeout_d = !hz.mdu_done;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : outputs
        hz.Stall_F     = 1'b0;
        hz.Stall_D     = 1'b0;
        hz.Stall_E     = 1'b0;
        hz.Flush_D     = 1'b0;
        hz.Flush_E     = 1'b0;
        hz.Flush_M     = 1'b0;
        hz.mdu_start   = 1'b0;
        hz.mdu_timeout = 1'b0;
        hz.mdu_busy    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    // Redirect first: a dependent instruction in ID is flushed anyway.
                    if (redirect) begin
                        hz.Flush_D = 1'b1;
                        hz.Flush_E = 1'b1;
                    end else if (hz.MulDiv_E) begin
                        hz.mdu_start = 1'b1;
                        hz.Stall_F   = 1'b1;
                        hz.Stall_D   = 1'b1;
                        hz.Stall_E   = 1'b1;
                        hz.Flush_M   = 1'b1;
                    end else if (lw_hazard) begin
                        hz.Stall_F = 1'b1;
                        hz.Stall_D = 1'b1;
                        hz.Flush_E = 1'b1;
                    end
                end
                StBusy: begin
                    hz.Stall_F  = 1'b1;
                    hz.Stall_D  = 1'b1;
                    hz.Stall_E  = 1'b1;
                    hz.Flush_M  = 1'b1;
                    hz.mdu_busy = 1'b1;
                end
                StDone:  hz.mdu_timeout = timeout_q;
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (hz.Stall_F) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (hz.Flush_D) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// against an operation-level reference model.
module tb_hazard_sequencer;
    localparam int unsigned MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_sequencer_if hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    hazard_sequencer #(
        .MDU_MAX_CYCLES(MAX),
        .CNT_W         (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
`endif
        .hz          (hz)
    );

    // {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, mdu_start, mdu_timeout, mdu_busy}
    logic [8:0] obs;
    assign obs = {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_D, hz.Flush_E, hz.Flush_M,
                  hz.mdu_start, hz.mdu_timeout, hz.mdu_busy};

    int checks = 0;
    int errors = 0;

    // Reference model: one multi-cycle op in flight, counted in elapsed busy cycles.
    bit op_in_flight = 0;
    int op_busy_elapsed = 0;
    bit op_retiring = 0;
    bit op_retire_timeout = 0;
    int ref_stalls = 0;
    int ref_flushes = 0;

    function automatic logic [8:0] model_out();
        bit lw;
        lw = (hz.ResultSrc_E == 2'b01) && (hz.rd_E != 0) &&
             ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
        if (rst) return 9'b0;
        if (op_retiring) return {7'b0, op_retire_timeout, 1'b0};
        if (op_in_flight) return 9'b111_001_001;
        if (hz.PCSrc_E != 0) return 9'b000_110_000;
        if (hz.MulDiv_E) return 9'b111_001_100;
        if (lw) return 9'b110_010_000;
        return 9'b0;
    endfunction

    task automatic model_step(input logic [8:0] expv);
        if (rst) begin
            op_in_flight = 0; op_retiring = 0; op_retire_timeout = 0;
            ref_stalls = 0; ref_flushes = 0;
        end else begin
            if (expv[8]) ref_stalls++;
            if (expv[5]) ref_flushes++;
            if (op_retiring) begin
                op_retiring = 0;
                op_retire_timeout = 0;
            end else if (op_in_flight) begin
                op_busy_elapsed++;
                if (hz.mdu_done) begin
                    op_in_flight = 0; op_retiring = 1; op_retire_timeout = 0;
                end else if (op_busy_elapsed == MAX) begin
                    op_in_flight = 0; op_retiring = 1; op_retire_timeout = 1;
                end
            end else if (hz.MulDiv_E && hz.PCSrc_E == 0) begin
                op_in_flight = 1;
                op_busy_elapsed = 0;
            end
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rde,
                         input logic [1:0] rs, input logic [1:0] pcs, input logic md,
                         input logic dn);
        hz.rs1_D = r1; hz.rs2_D = r2; hz.rd_E = rde;
        hz.ResultSrc_E = rs; hz.PCSrc_E = pcs; hz.MulDiv_E = md; hz.mdu_done = dn;
    endtask

    task automatic test_reset();
        logic [8:0] expv;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'd3, 5'd3, 5'd3, 2'b01, 2'(i), 1'b1, 1'b1);
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== 9'b0 || obs !== expv) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b want %b", i, obs, expv);
            end
            model_step(expv);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [8:0] expv;
        // rd=5 vs rs1=5, then rd=0 vs rs1=0, then rd=9 vs rs2=9, then a non-load
        logic [4:0] rdv [4] = '{5'd5, 5'd0, 5'd9, 5'd9};
        logic [4:0] r1v [4] = '{5'd5, 5'd0, 5'd1, 5'd9};
        logic [4:0] r2v [4] = '{5'd2, 5'd0, 5'd9, 5'd9};
        logic [1:0] rsv [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(r1v[i/2], r2v[i/2], rdv[i/2], rsv[i/2], 2'b00, 1'b0, 1'b0);
            else drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL load_use cyc %0d: got %b want %b", i, obs, expv);
            end
            model_step(expv);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        logic [8:0] expv;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(5'd1, 5'd7, 5'd7, 2'b01, 2'b01, 1'b0, 1'b0);
            else if (i == 1) drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b10, 1'b1, 1'b0);
            else drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL redirect cyc %0d: got %b want %b", i, obs, expv);
            end
            model_step(expv);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv();
        logic [8:0] expv;
        int starts = 0, stalls = 0, busys = 0;
        for (int i = 0; i < 8; i++) begin
            drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, logic'(i <= 5), logic'(i == 4));
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL muldiv cyc %0d: got %b want %b", i, obs, expv);
            end
            starts += int'(hz.mdu_start);
            stalls += int'(hz.Stall_F && hz.Stall_E && hz.Flush_M);
            busys  += int'(hz.mdu_busy);
            model_step(expv);
            @(posedge clk); #1;
        end
        checks++;
        if (starts != 1 || stalls != 5 || busys != 4) begin
            errors++;
            $display("FAIL muldiv_counts: got start=%0d stall=%0d busy=%0d want 1/5/4",
                     starts, stalls, busys);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expv;
        int starts = 0, first = -1, second = -1;
        for (int i = 0; i < 10; i++) begin
            drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, logic'(i <= 7), logic'(i == 2 || i == 6));
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, expv);
            end
            if (hz.mdu_start) begin
                starts++;
                if (first < 0) first = i; else second = i;
            end
            model_step(expv);
            @(posedge clk); #1;
        end
        checks++;
        // start, two busy cycles, DONE, then re-entry start
        if (starts != 2 || second - first != 4) begin
            errors++;
            $display("FAIL back_to_back_starts: got %0d starts gap %0d want 2 gap 4",
                     starts, second - first);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] expv;
        int pulses = 0, at = -1;
        for (int pass = 0; pass < 2; pass++) begin
            pulses = 0; at = -1;
            for (int i = 0; i < 12; i++) begin
                // pass 1: done arrives on the last allowed busy cycle
                drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, logic'(i <= int'(MAX) + 1),
                      logic'(pass == 1 && i == int'(MAX)));
                @(negedge clk);
                expv = model_out();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL timeout p%0d cyc %0d: got %b want %b", pass, i, obs, expv);
                end
                if (hz.mdu_timeout) begin
                    pulses++;
                    at = i;
                end
                model_step(expv);
                @(posedge clk); #1;
            end
            checks++;
            if (pass == 0 && (pulses != 1 || at != int'(MAX) + 1)) begin
                errors++;
                $display("FAIL timeout_pulse: got %0d at %0d want 1 at %0d", pulses, at, MAX + 1);
            end else if (pass == 1 && pulses != 0) begin
                errors++;
                $display("FAIL done_beats_timeout: got %0d pulses want 0", pulses);
            end
        end
    endtask

    task automatic test_reset_busy();
        logic [8:0] expv;
        int pulses = 0;
        for (int i = 0; i < 12; i++) begin
            rst = logic'(i == 3);
            drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, logic'(i <= 3), 1'b0);
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_busy cyc %0d: got %b want %b", i, obs, expv);
            end
            pulses += int'(hz.mdu_timeout);
            model_step(expv);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_busy_timeout: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_random();
        logic [8:0] expv;
        for (int i = 0; i < 400; i++) begin
            rst = logic'($urandom_range(99) < 2);
            drive(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                  2'($urandom_range(3)),
                  ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                  logic'($urandom_range(4) == 0), logic'($urandom_range(6) == 0));
            @(negedge clk);
            expv = model_out();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs, expv);
            end
            model_step(expv);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        // let any op left in flight drain
        for (int i = 0; i < int'(MAX) + 2; i++) begin
            @(negedge clk);
            model_step(model_out());
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        logic [8:0] expv;
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        model_step(model_out());
        @(posedge clk); #1;
        rst = 1'b0;
        test_muldiv();
        drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        expv = model_out();
        model_step(expv);
        @(posedge clk); #1;
        drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd5 || flush_events !== 32'd1 ||
            int'(stall_cycles) != ref_stalls || int'(flush_events) != ref_flushes) begin
            errors++;
            $display("FAIL perf: got stall=%0d flush=%0d want 5/1 (model %0d/%0d)",
                     stall_cycles, flush_events, ref_stalls, ref_flushes);
        end
        model_step(model_out());
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_muldiv();
        test_back_to_back();
        test_timeout();
        test_reset_busy();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
